// File: rtl/fetch_stage.sv
// RV32I instruction-fetch front end: owns the PC, keeps one imem request in flight,
// buffers up to two fetched words and presents the head to the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_select,
  input  logic [31:0] jal_target,
  input  logic        jalr,
  input  logic [31:0] jalr_target,
  input  logic        branch_result,
  input  logic [31:0] branch_target,
  input  logic        load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pre_address_pc,
  output logic [31:0] instruction_fetch,
  output logic        fetch_misaligned
);

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_SQUASH} state_t;

  localparam logic [2:0] OCC_MAX = 3'(BUF_DEPTH - 1);

  state_t           state;
  logic [31:0]      pc, req_pc, target;
  logic [1:0][31:0] buf_pc, buf_ins;
  logic [1:0]       count, wr_sel;
  logic [2:0]       occ_next;
  logic             redirect, pop, push, accept;
  logic             unused_jalr_lsb;

  assign unused_jalr_lsb = jalr_target[0];

  assign redirect = branch_result | jalr | next_select;
  assign pop      = (count != 2'd0) & ~load & ~redirect;
  assign push     = imem_rvalid & (state == WAIT) & ~redirect;
  assign occ_next = {1'b0, count} - {2'b0, pop} + {2'b0, push};
  // Slot a push lands in, after any same-cycle pop has shifted entry 1 down.
  assign wr_sel   = count - {1'b0, pop};

  always_comb begin
    target = jal_target;
    if (jalr)          target = {jalr_target[31:1], 1'b0};
    if (branch_result) target = branch_target;
  end

  // Issue only when the word can be guaranteed a buffer slot on return.
  assign imem_req  = ~rst & ~redirect &
                     ((state == IDLE) | ((state == WAIT) & imem_rvalid)) &
                     (occ_next <= OCC_MAX);
  assign imem_addr = pc;
  assign accept    = imem_req & imem_ready;

  assign pre_address_pc    = (count != 2'd0) ? buf_pc[0]  : 32'h0;
  assign instruction_fetch = (count != 2'd0) ? buf_ins[0] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc               <= RESET_PC;
      req_pc           <= RESET_PC;
      count            <= 2'd0;
      state            <= IDLE;
      fetch_misaligned <= 1'b0;
      buf_pc           <= '0;
      buf_ins          <= '0;
    end else begin
      fetch_misaligned <= redirect & (target[1:0] != 2'b00);
      if (redirect) begin
        pc    <= {target[31:2], 2'b00};
        count <= 2'd0;
        // A response landing in the redirect cycle retires the outstanding request.
        if (state != IDLE) state <= imem_rvalid ? IDLE : WAIT_SQUASH;
      end else begin
        count <= occ_next[1:0];
        if (accept) begin
          pc     <= pc + 32'd4;
          req_pc <= pc;
        end
        case (state)
          IDLE:        if (accept) state <= WAIT;
          WAIT:        if (imem_rvalid) state <= accept ? WAIT : IDLE;
          WAIT_SQUASH: if (imem_rvalid) state <= IDLE;
          default:     state <= IDLE;
        endcase
        if (pop) begin
          buf_pc[0]  <= buf_pc[1];
          buf_ins[0] <= buf_ins[1];
        end
        if (push) begin
          buf_pc[wr_sel[0]]  <= req_pc;
          buf_ins[wr_sel[0]] <= imem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model returning addr|0x13 with programmable latency,
// a scoreboard of expected {pc, instruction} per path, and directed timing checks.
module tb_fetch_stage;

  logic        clk, rst;
  logic        next_select, jalr, branch_result, load;
  logic [31:0] jal_target, jalr_target, branch_target;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pre_address_pc, instruction_fetch;
  logic        fetch_misaligned;

  logic        mem_rvalid, stray;
  logic [31:0] mem_rdata;
  int          lat;
  int          n_chk, n_fail;

  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  exp_t sb[$];

  assign imem_rvalid = mem_rvalid | stray;
  assign imem_rdata  = stray ? 32'hDEAD_0013 : mem_rdata;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .next_select(next_select), .jal_target(jal_target),
    .jalr(jalr), .jalr_target(jalr_target),
    .branch_result(branch_result), .branch_target(branch_target),
    .load(load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pre_address_pc(pre_address_pc), .instruction_fetch(instruction_fetch),
    .fetch_misaligned(fetch_misaligned)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic sb_load(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc  = start + 32'(4 * i);
      e.ins = e.pc | 32'h13;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) cyc();
    chk({"drain_", tag}, 32'(sb.size()), 32'h0);
  endtask

  task automatic wait_accept(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      smp();
      seen = imem_req && imem_ready;
      cyc();
    end
    chk({"accept_", tag}, 32'(seen), 32'h1);
  endtask

  // Memory: decide acceptance from values stable before the edge, update after it.
  initial begin
    bit          acc, kill, pend;
    int          cnt;
    logic [31:0] a, paddr;
    pend = 0; cnt = 0; paddr = 0;
    mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      acc  = imem_req && imem_ready;
      a    = imem_addr;
      kill = rst;
      @(posedge clk); #1;
      mem_rvalid = 0;
      if (kill) pend = 0;
      else begin
        if (acc) begin
          chk("one_outstanding", 32'(pend), 32'h0);
          pend = 1; cnt = lat; paddr = a;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_rvalid = 1;
            mem_rdata  = paddr | 32'h13;
            pend       = 0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: a head is consumed when shown with no stall and no redirect.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_rvalid) chk("rvalid_with_full", 32'(dut.count == 2'd2), 32'h0);
      if (instruction_fetch == 32'h0) chk("bubble_pc", pre_address_pc, 32'h0);
      else if (!load && !(branch_result || jalr || next_select) && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", pre_address_pc, e.pc);
        chk("sb_ins", instruction_fetch, e.ins);
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1; load = 0; stray = 0; lat = 1; imem_ready = 1;
    next_select = 0; jalr = 0; branch_result = 0;
    jal_target = 0; jalr_target = 0; branch_target = 0;
    cyc(); cyc();
    smp();
    chk("rst_pc", pre_address_pc, 32'h0);
    chk("rst_ins", instruction_fetch, 32'h0);
    chk("rst_mis", 32'(fetch_misaligned), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    cyc();
    sb_load(32'h0, 32);
    rst = 0;
    // Streaming start-up: first word visible two cycles after reset release.
    for (int k = 0; k < 4; k++) begin
      smp();
      if (k == 0) chk("c0_bubble", instruction_fetch, 32'h0);
      if (k >= 2) begin
        chk("start_pc", pre_address_pc, 32'(4 * (k - 2)));
        chk("start_ins", instruction_fetch, 32'(4 * (k - 2)) | 32'h13);
      end
      cyc();
    end
    load = 1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("ld_pc", pre_address_pc, 32'h8);
      chk("ld_ins", instruction_fetch, 32'h1B);
      chk("ld_req", 32'(imem_req), 32'h0);
      cyc();
    end
    load = 0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("rel_pc", pre_address_pc, 32'(8 + 4 * k));
      chk("rel_ins", instruction_fetch, 32'(8 + 4 * k) | 32'h13);
      cyc();
    end

    // Branch while a slow request is outstanding.
    lat = 3;
    wait_accept("br");
    branch_result = 1; branch_target = 32'h100;
    sb_load(32'h100, 4);
    cyc();
    branch_result = 0;
    smp();
    chk("br_flush_pc", pre_address_pc, 32'h0);
    chk("br_flush_ins", instruction_fetch, 32'h0);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_mis", 32'(fetch_misaligned), 32'h0);
    cyc();
    drain("br");

    // Redirect priority and target alignment.
    lat = 1;
    branch_result = 1; jalr = 1; next_select = 1;
    branch_target = 32'h200; jalr_target = 32'h300; jal_target = 32'h400;
    sb_load(32'h200, 4);
    cyc();
    branch_result = 0; jalr = 0; next_select = 0;
    smp();
    chk("prio_addr", imem_addr, 32'h200);
    cyc();
    drain("prio");

    jalr = 1; jalr_target = 32'h305;
    sb_load(32'h304, 4);
    cyc();
    jalr = 0;
    smp();
    chk("jalr5_addr", imem_addr, 32'h304);
    cyc();
    drain("jalr5");

    jalr = 1; jalr_target = 32'h306;
    sb_load(32'h304, 2);
    cyc();
    jalr = 0;
    smp();
    chk("jalr6_mis", 32'(fetch_misaligned), 32'h1);
    chk("jalr6_addr", imem_addr, 32'h304);
    cyc();
    smp();
    chk("jalr6_mis_off", 32'(fetch_misaligned), 32'h0);
    cyc();
    drain("jalr6");

    next_select = 1; jal_target = 32'h503;
    sb_load(32'h500, 2);
    cyc();
    next_select = 0;
    smp();
    chk("jal_mis", 32'(fetch_misaligned), 32'h1);
    chk("jal_addr", imem_addr, 32'h500);
    cyc();
    drain("jal");

    // Memory not ready, then slow responses.
    lat = 3; imem_ready = 0;
    branch_result = 1; branch_target = 32'h600;
    sb_load(32'h600, 4);
    cyc();
    branch_result = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("nrdy_pc", pre_address_pc, 32'h0);
      chk("nrdy_ins", instruction_fetch, 32'h0);
      cyc();
    end
    imem_ready = 1;
    drain("slow");

    // Reset during an outstanding request, then a stray response.
    wait_accept("rst");
    rst = 1;
    smp();
    chk("mid_rst_pc", pre_address_pc, 32'h0);
    chk("mid_rst_ins", instruction_fetch, 32'h0);
    chk("mid_rst_req", 32'(imem_req), 32'h0);
    cyc();
    rst = 0; imem_ready = 0; stray = 1;
    sb_load(32'h0, 4);
    smp();
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req", 32'(imem_req), 32'h1);
    cyc();
    stray = 0;
    smp();
    chk("stray_pc", pre_address_pc, 32'h0);
    chk("stray_ins", instruction_fetch, 32'h0);
    cyc();
    imem_ready = 1; lat = 1;
    drain("rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
